// File: rtl/arm_pkg.sv
// Shared ARM decode constants: instruction modes, opcodes, EXE commands,
// condition codes, NZCV flag positions and the decoded control bundle.
package arm_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int unsigned SR_N = 3;
  localparam int unsigned SR_Z = 2;
  localparam int unsigned SR_C = 1;
  localparam int unsigned SR_V = 0;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic       imm;
    logic [3:0] exe_cmd;
  } ctrl_t;

  // Data-processing opcode to ALU command; unsupported opcodes issue as NOP.
  function automatic logic [3:0] op_to_cmd(input logic [3:0] op);
    logic [3:0] cmd;
    case (op)
      OP_AND:  cmd = CMD_AND;
      OP_EOR:  cmd = CMD_EOR;
      OP_SUB:  cmd = CMD_SUB;
      OP_ADD:  cmd = CMD_ADD;
      OP_ADC:  cmd = CMD_ADC;
      OP_SBC:  cmd = CMD_SBC;
      OP_TST:  cmd = CMD_AND;
      OP_CMP:  cmd = CMD_SUB;
      OP_ORR:  cmd = CMD_ORR;
      OP_MOV:  cmd = CMD_MOV;
      OP_MVN:  cmd = CMD_MVN;
      default: cmd = CMD_NOP;
    endcase
    return cmd;
  endfunction

  // Condition field evaluated against NZCV; the 1111 encoding never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, pass;
    n = flags[SR_N];
    z = flags[SR_Z];
    c = flags[SR_C];
    v = flags[SR_V];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports, one clocked write port,
// and same-cycle writeback bypass onto both reads.
module regfile_bypass #(
  parameter int unsigned NREG   = 16,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_we && (i_raddr1 == i_waddr)) ? i_wdata : r_mem[i_raddr1];
  assign o_rdata2 = (i_we && (i_raddr2 == i_waddr)) ? i_wdata : r_mem[i_raddr2];

endmodule

// File: rtl/decode_stage_pipe.sv
// ARM decode stage: field decode, register read with writeback bypass, hazard
// detection and a valid/ready pipeline register feeding EXE.
module decode_stage_pipe
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 16,
  parameter int unsigned RA_W   = 4,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        sr,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [RA_W-1:0]   exe_dest,
  input  logic              mem_wb_en,
  input  logic [RA_W-1:0]   mem_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              o_wb_en,
  output logic              o_mem_r_en,
  output logic              o_mem_w_en,
  output logic              o_b,
  output logic              o_s,
  output logic              o_imm,
  output logic [3:0]        o_exe_cmd,
  output logic [DATA_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_val_rn,
  output logic [DATA_W-1:0] o_val_rm,
  output logic [11:0]       o_shift_op,
  output logic [23:0]       o_imm24,
  output logic [RA_W-1:0]   o_dest,
  output logic [RA_W-1:0]   o_src1,
  output logic [RA_W-1:0]   o_src2,
  output logic              stall
);

  logic [3:0]        w_cond;
  logic [1:0]        w_mode;
  logic              w_ibit;
  logic [3:0]        w_opcode;
  logic              w_sbit;
  logic [RA_W-1:0]   w_rn;
  logic [RA_W-1:0]   w_rd;
  logic [RA_W-1:0]   w_rm;
  logic [RA_W-1:0]   w_src2;
  ctrl_t             w_ctrl;
  logic              w_is_store;
  logic              w_src1_used;
  logic              w_src2_used;
  logic              w_hit_exe;
  logic              w_hit_mem;
  logic              w_hazard;
  logic              w_advance;
  logic [DATA_W-1:0] w_val_rn;
  logic [DATA_W-1:0] w_val_rm;

  ctrl_t             r_ctrl;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_val_rn;
  logic [DATA_W-1:0] r_val_rm;
  logic [11:0]       r_shift_op;
  logic [23:0]       r_imm24;
  logic [RA_W-1:0]   r_dest;
  logic [RA_W-1:0]   r_src1;
  logic [RA_W-1:0]   r_src2;

  assign w_cond   = instr[31:28];
  assign w_mode   = instr[27:26];
  assign w_ibit   = instr[25];
  assign w_opcode = instr[24:21];
  assign w_sbit   = instr[20];
  assign w_rn     = RA_W'(instr[19:16]);
  assign w_rd     = RA_W'(instr[15:12]);
  assign w_rm     = RA_W'(instr[3:0]);
  assign w_src2   = w_is_store ? w_rd : w_rm;

  // Control decode; a failed condition turns the instruction into a no-op.
  always_comb begin
    w_ctrl      = '0;
    w_is_store  = 1'b0;
    w_src1_used = 1'b1;
    case (w_mode)
      MODE_DP: begin
        w_ctrl.wb_en   = !((w_opcode == OP_CMP) || (w_opcode == OP_TST));
        w_ctrl.exe_cmd = op_to_cmd(w_opcode);
        w_ctrl.s       = w_sbit;
        w_ctrl.imm     = w_ibit;
        w_src1_used    = !((w_opcode == OP_MOV) || (w_opcode == OP_MVN));
      end
      MODE_MEM: begin
        w_ctrl.exe_cmd  = CMD_ADD;
        w_ctrl.imm      = w_ibit;
        w_ctrl.mem_r_en = w_sbit;
        w_ctrl.wb_en    = w_sbit;
        w_ctrl.mem_w_en = !w_sbit;
        w_is_store      = !w_sbit;
      end
      MODE_BR: begin
        w_ctrl.b    = 1'b1;
        w_src1_used = 1'b0;
      end
      default: ;
    endcase
    w_src2_used = w_is_store || ((w_mode == MODE_DP) && !w_ibit);
    if (!cond_pass(w_cond, sr)) w_ctrl = '0;
  end

  assign w_hit_exe = (w_src1_used && (w_rn == exe_dest)) || (w_src2_used && (w_src2 == exe_dest));
  assign w_hit_mem = (w_src1_used && (w_rn == mem_dest)) || (w_src2_used && (w_src2 == mem_dest));

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    if (FWD_EN) w_hazard = in_valid && exe_mem_r_en && w_hit_exe;
    else        w_hazard = in_valid && ((exe_wb_en && w_hit_exe) || (mem_wb_en && w_hit_mem));
  end

  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = rst && w_advance && !w_hazard && !flush;
  assign stall     = w_hazard;

  regfile_bypass #(
    .NREG   (NREG),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .i_rst_n  (rst),
    .i_we     (wb_en),
    .i_waddr  (wb_dest),
    .i_wdata  (wb_data),
    .i_raddr1 (w_rn),
    .i_raddr2 (w_src2),
    .o_rdata1 (w_val_rn),
    .o_rdata2 (w_val_rm)
  );

  // Pipeline register: flush beats load; a hazard on advance inserts a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_pc        <= '0;
      r_val_rn    <= '0;
      r_val_rm    <= '0;
      r_shift_op  <= '0;
      r_imm24     <= '0;
      r_dest      <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
    end else if (w_advance) begin
      if (w_hazard) begin
        r_out_valid <= 1'b0;
        r_ctrl      <= '0;
      end else begin
        r_out_valid <= in_valid;
        r_ctrl      <= w_ctrl;
        r_pc        <= pc_in;
        r_val_rn    <= w_val_rn;
        r_val_rm    <= w_val_rm;
        r_shift_op  <= instr[11:0];
        r_imm24     <= instr[23:0];
        r_dest      <= w_rd;
        r_src1      <= w_rn;
        r_src2      <= w_src2;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign o_wb_en    = r_ctrl.wb_en;
  assign o_mem_r_en = r_ctrl.mem_r_en;
  assign o_mem_w_en = r_ctrl.mem_w_en;
  assign o_b        = r_ctrl.b;
  assign o_s        = r_ctrl.s;
  assign o_imm      = r_ctrl.imm;
  assign o_exe_cmd  = r_ctrl.exe_cmd;
  assign o_pc       = r_pc;
  assign o_val_rn   = r_val_rn;
  assign o_val_rm   = r_val_rm;
  assign o_shift_op = r_shift_op;
  assign o_imm24    = r_imm24;
  assign o_dest     = r_dest;
  assign o_src1     = r_src1;
  assign o_src2     = r_src2;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed spec vectors followed by random traffic,
// all checked cycle by cycle against an instruction-level reference model.
module tb_decode_stage_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam logic [31:0] ADD_R1_R2_R3 = 32'hE0821003;

  logic          clk = 1'b0;
  logic          rst, in_valid, flush, wb_en, exe_wb_en, exe_mem_r_en, mem_wb_en, out_ready;
  logic [31:0]   instr;
  logic [DW-1:0] pc_in, wb_data;
  logic [3:0]    sr;
  logic [AW-1:0] wb_dest, exe_dest, mem_dest;

  logic          in_ready, out_valid, o_wb_en, o_mem_r_en, o_mem_w_en, o_b, o_s, o_imm, stall;
  logic [3:0]    o_exe_cmd;
  logic [DW-1:0] o_pc, o_val_rn, o_val_rm;
  logic [11:0]   o_shift_op;
  logic [23:0]   o_imm24;
  logic [AW-1:0] o_dest, o_src1, o_src2;

  logic          nf_in_ready, nf_out_valid, nf_wb_en, nf_mem_r_en, nf_mem_w_en, nf_b, nf_s, nf_imm, nf_stall;
  logic [3:0]    nf_exe_cmd;
  logic [DW-1:0] nf_pc, nf_val_rn, nf_val_rm;
  logic [11:0]   nf_shift_op;
  logic [23:0]   nf_imm24;
  logic [AW-1:0] nf_dest, nf_src1, nf_src2;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(DW), .NREG(16), .RA_W(AW), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc_in(pc_in), .sr(sr), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_data(wb_data), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .out_valid(out_valid), .out_ready(out_ready), .o_wb_en(o_wb_en),
    .o_mem_r_en(o_mem_r_en), .o_mem_w_en(o_mem_w_en), .o_b(o_b), .o_s(o_s),
    .o_imm(o_imm), .o_exe_cmd(o_exe_cmd), .o_pc(o_pc), .o_val_rn(o_val_rn),
    .o_val_rm(o_val_rm), .o_shift_op(o_shift_op), .o_imm24(o_imm24),
    .o_dest(o_dest), .o_src1(o_src1), .o_src2(o_src2), .stall(stall)
  );

  // Second instance without forwarding; only its stall output is judged.
  decode_stage_pipe #(.DATA_W(DW), .NREG(16), .RA_W(AW), .FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nf_in_ready), .instr(instr),
    .pc_in(pc_in), .sr(sr), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_data(wb_data), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .out_valid(nf_out_valid), .out_ready(out_ready), .o_wb_en(nf_wb_en),
    .o_mem_r_en(nf_mem_r_en), .o_mem_w_en(nf_mem_w_en), .o_b(nf_b), .o_s(nf_s),
    .o_imm(nf_imm), .o_exe_cmd(nf_exe_cmd), .o_pc(nf_pc), .o_val_rn(nf_val_rn),
    .o_val_rm(nf_val_rm), .o_shift_op(nf_shift_op), .o_imm24(nf_imm24),
    .o_dest(nf_dest), .o_src1(nf_src1), .o_src2(nf_src2), .stall(nf_stall)
  );

  typedef struct {
    logic        valid;
    logic [9:0]  ctl;
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic [23:0] i24;
    logic [3:0]  dest, s1, s2;
  } bundle_t;

  // ALU command per data-processing opcode: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN
  logic [3:0]  cmd_tab [16] = '{4'h6, 4'h8, 4'h4, 4'h0, 4'h2, 4'h3, 4'h5, 4'h0,
                                4'h6, 4'h0, 4'h4, 4'h0, 4'h7, 4'h1, 4'h0, 4'h9};
  logic [31:0] m_rf [16];
  bundle_t     exp_q;
  bit          was_rst;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    logic [15:0] t;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    t = {1'b0, 1'b1, z || (n != v), !z && (n == v), n != v, n == v, !cy || z, cy && !z,
         !v, v, !n, n, !cy, cy, !z, z};
    return t[c];
  endfunction

  // Expected controls {wb,mem_r,mem_w,b,s,imm,cmd} and source usage of one instruction.
  function automatic void m_decode(input logic [31:0] ins, input logic [3:0] f,
                                   output logic [9:0] ctl, output logic [3:0] s1,
                                   output logic [3:0] s2, output bit u1, output bit u2);
    bit dp, ld, st, br, ib, sb, wb;
    logic [3:0] op, cmd;
    op = ins[24:21]; ib = ins[25]; sb = ins[20];
    dp = (ins[27:26] == 2'b00);
    ld = (ins[27:26] == 2'b01) && sb;
    st = (ins[27:26] == 2'b01) && !sb;
    br = (ins[27:26] == 2'b10);
    wb = (dp && op != 4'd10 && op != 4'd8) || ld;
    cmd = dp ? cmd_tab[op] : ((ld || st) ? 4'h2 : 4'h0);
    ctl = {wb, ld, st, br, dp && sb, (dp || ld || st) && ib, cmd};
    if (!m_cond(ins[31:28], f)) ctl = '0;
    s1 = ins[19:16];
    s2 = st ? ins[15:12] : ins[3:0];
    u1 = !(br || (dp && (op == 4'd13 || op == 4'd15)));
    u2 = st || (dp && !ib);
  endfunction

  function automatic bit m_hazard(input bit fwd, input bit u1, input bit u2,
                                  input logic [3:0] s1, input logic [3:0] s2);
    logic [3:0] srcs [$];
    if (!in_valid) return 1'b0;
    if (u1) srcs.push_back(s1);
    if (u2) srcs.push_back(s2);
    foreach (srcs[k]) begin
      if (fwd && exe_mem_r_en && srcs[k] == exe_dest) return 1'b1;
      if (!fwd && ((exe_wb_en && srcs[k] == exe_dest) || (mem_wb_en && srcs[k] == mem_dest))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    return (wb_en && wb_dest == a) ? wb_data : m_rf[a];
  endfunction

  task automatic check_out();
    chk("out_valid", out_valid, exp_q.valid);
    chk("ctrl", {o_wb_en, o_mem_r_en, o_mem_w_en, o_b, o_s, o_imm, o_exe_cmd}, exp_q.ctl);
    if (exp_q.valid || was_rst) begin
      chk("o_pc", o_pc, exp_q.pc);
      chk("o_val_rn", o_val_rn, exp_q.rn);
      chk("o_val_rm", o_val_rm, exp_q.rm);
      chk("fields", {o_shift_op, o_imm24, o_dest, o_src1, o_src2},
          {exp_q.sh, exp_q.i24, exp_q.dest, exp_q.s1, exp_q.s2});
    end
  endtask

  // One clock: judge combinational outputs, advance the model, judge registered outputs.
  task automatic cycle();
    logic [9:0] ctl;
    logic [3:0] s1, s2;
    bit u1, u2, haz, adv;
    bundle_t nx;
    #1;
    m_decode(instr, sr, ctl, s1, s2, u1, u2);
    haz = m_hazard(1'b1, u1, u2, s1, s2);
    adv = !exp_q.valid || out_ready;
    chk("stall", stall, haz);
    chk("stall_nofwd", nf_stall, m_hazard(1'b0, u1, u2, s1, s2));
    chk("in_ready", in_ready, rst && adv && !haz && !flush);
    nx = exp_q;
    if (!rst) begin
      nx = '{default: '0};
    end else if (flush || (adv && haz)) begin
      nx.valid = 1'b0;
      nx.ctl   = '0;
    end else if (adv) begin
      nx.valid = in_valid;
      nx.ctl   = ctl;
      nx.pc    = pc_in;
      nx.rn    = m_read(s1);
      nx.rm    = m_read(s2);
      nx.sh    = instr[11:0];
      nx.i24   = instr[23:0];
      nx.dest  = instr[15:12];
      nx.s1    = s1;
      nx.s2    = s2;
    end
    @(posedge clk);
    if (!rst) foreach (m_rf[k]) m_rf[k] = '0;
    else if (wb_en) m_rf[wb_dest] = wb_data;
    exp_q   = nx;
    was_rst = !rst;
    #1;
    check_out();
  endtask

  task automatic idle_inputs();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; exe_wb_en = 1'b0;
    exe_mem_r_en = 1'b0; mem_wb_en = 1'b0; out_ready = 1'b1; instr = '0; pc_in = '0;
    sr = '0; wb_dest = '0; wb_data = '0; exe_dest = '0; mem_dest = '0;
  endtask

  initial begin
    logic [31:0] ri;
    exp_q = '{default: '0};
    foreach (m_rf[k]) m_rf[k] = '0;
    idle_inputs();

    // Reset held two cycles while fetch offers an instruction.
    rst = 1'b0; in_valid = 1'b1; instr = ADD_R1_R2_R3; pc_in = 32'h40;
    repeat (2) begin
      cycle();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
    end

    // Every register reads zero after reset.
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      instr = 32'hE0800000 | (32'(i) << 16) | 32'(i);
      pc_in = 32'(i * 4);
      cycle();
      chk("rf_zero", o_val_rn, 32'h0);
    end

    // Load the register file through the writeback port.
    in_valid = 1'b0; wb_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wb_dest = 4'(i);
      wb_data = (i == 2) ? 32'd5 : ((i == 3) ? 32'd7 : $urandom);
      cycle();
    end
    wb_en = 1'b0;

    // ADD R1,R2,R3.
    in_valid = 1'b1; instr = ADD_R1_R2_R3; pc_in = 32'h80;
    cycle();
    chk("add_valid", out_valid, 1'b1);
    chk("add_cmd", o_exe_cmd, 4'h2);
    chk("add_rn", o_val_rn, 32'd5);
    chk("add_rm", o_val_rm, 32'd7);
    chk("add_dest", o_dest, 4'd1);

    // Same ADD while R2 is being written back.
    wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'hAA;
    cycle();
    chk("bypass_rn", o_val_rn, 32'hAA);
    wb_en = 1'b0;

    // Load in EXE targeting R2: one bubble, then the ADD issues once.
    exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd2; pc_in = 32'h84;
    cycle();
    chk("lu_stall", stall, 1'b1);
    chk("lu_in_ready", in_ready, 1'b0);
    chk("lu_bubble", out_valid, 1'b0);
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    cycle();
    chk("lu_issue", out_valid, 1'b1);
    chk("lu_pc", o_pc, 32'h84);
    in_valid = 1'b0;
    cycle();
    chk("lu_once", out_valid, 1'b0);

    // Backpressure freezes the bundle; flush then kills it despite out_ready=0.
    in_valid = 1'b1; pc_in = 32'h100;
    cycle();
    out_ready = 1'b0; pc_in = 32'h200; instr = 32'hE1A05006;
    repeat (3) begin
      cycle();
      chk("bp_pc", o_pc, 32'h100);
      chk("bp_valid", out_valid, 1'b1);
    end
    flush = 1'b1;
    cycle();
    chk("flush_valid", out_valid, 1'b0);
    flush = 1'b0; out_ready = 1'b1;

    // EQ-conditioned ADD: controls zero with Z clear, live with Z set.
    instr = 32'h00821003; sr = 4'b0000;
    cycle();
    chk("condfail_valid", out_valid, 1'b1);
    chk("condfail_ctrl", {o_wb_en, o_mem_r_en, o_mem_w_en, o_b, o_s, o_imm, o_exe_cmd}, 10'h0);
    sr = 4'b0100;
    cycle();
    chk("condpass_wb", o_wb_en, 1'b1);

    // Reset with a bundle stalled in the register.
    out_ready = 1'b0; sr = 4'b0;
    cycle();
    rst = 1'b0;
    cycle();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_pc", o_pc, 32'h0);
    idle_inputs();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 3) != 0) ri[31:28] = 4'hE;
      instr        = ri;
      rst          = ($urandom_range(0, 59) != 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      pc_in        = $urandom;
      sr           = 4'($urandom);
      flush        = ($urandom_range(0, 15) == 0);
      out_ready    = ($urandom_range(0, 9) < 7);
      wb_en        = $urandom_range(0, 1) == 1;
      wb_dest      = 4'($urandom);
      wb_data      = $urandom;
      exe_wb_en    = $urandom_range(0, 1) == 1;
      exe_mem_r_en = $urandom_range(0, 2) == 0;
      exe_dest     = ($urandom_range(0, 1) == 1) ? ri[19:16] : 4'($urandom);
      mem_wb_en    = $urandom_range(0, 1) == 1;
      mem_dest     = ($urandom_range(0, 1) == 1) ? ri[3:0] : 4'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
